vga_sync_timing: RTL and testbench
==================================

Name: vga_sync_timing

Overview:
- Consumer of the pixel rate: generates the 640x480@60 VGA raster timing (hsync, vsync, blanking, pixel coordinates) entirely in the vga_clk domain.
- Uses an internal single-cycle pixel strobe (pix_en) instead of a divided clock.
- Feeds the pixel ROM address path and the RGB output register stage.

Parameters:
- CLK_DIV, 2: vga_clk cycles per pixel; legal range ≥1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_POL, 0: sync active level; 0 = active-low.

Ports:
- vga_clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- pix_en  out  1  one-vga_clk pulse every CLK_DIV cycles.
- h_count  out  10  current pixel column, 0..H_TOTAL-1.
- v_count  out  10  current line, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync, level set by SYNC_POL.
- vsync  out  1  vertical sync, level set by SYNC_POL.
- video_on  out  1  high when h_count<H_ACTIVE and v_count<V_ACTIVE.
- line_start  out  1  one-cycle pulse when h_count becomes 0.
- frame_start  out  1  one-cycle pulse when (h_count,v_count) becomes (0,0).

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Strobe counter:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en is registered and high in the cycle after div_cnt==CLK_DIV-1.
  - CLK_DIV=1 → pix_en constantly high after reset.
  - First pix_en occurs CLK_DIV cycles after reset release.
- Raster counters advance only in cycles where pix_en=1:
  - h_count increments; at H_TOTAL-1 it wraps to 0.
  - v_count increments only on that h wrap; at V_TOTAL-1 it wraps to 0.
- Horizontal phase FSM (package enum): ACTIVE → FP → SYNC → BP → ACTIVE.
  - ACTIVE exits at h_count==H_ACTIVE-1, FP exits at H_ACTIVE+H_FP-1, SYNC exits at H_ACTIVE+H_FP+H_SYNC-1, BP exits at H_TOTAL-1.
  - Transitions occur on pix_en only.
  - The vertical FSM is identical, stepping on h wrap.
- Outputs:
  - All outputs are registered and coherent with the h_count/v_count values presented in the same cycle; they are computed from next-state values, so there is zero skew between counters and syncs.
  - hsync = SYNC_POL when the horizontal phase is SYNC (h_count 656..751), else ~SYNC_POL.
  - vsync = SYNC_POL when the vertical phase is SYNC (v_count 490..491), else ~SYNC_POL.
  - video_on is high only when both phases are ACTIVE.
- Pulses: line_start and frame_start are each high for exactly one vga_clk cycle, coincident with the counter update.
- Reset values:
  - h_count=H_TOTAL-1, v_count=V_TOTAL-1, FSMs in BP.
  - hsync=vsync=~SYNC_POL; video_on, line_start, frame_start, pix_en all 0; div_cnt=0.
  - The first pix_en therefore wraps the counters to (0,0) and fires frame_start and line_start.
- Reset mid-frame: outputs return to reset values asynchronously and the raster restarts cleanly; no partial line is emitted.
- Parameter constraints (elaboration-time check):
  - H_TOTAL ≤ 1024, V_TOTAL ≤ 1024.
  - Every porch and sync parameter ≥ 1.

Optional Feature:
- Macro: VGA_SYNC_TIMING_ROM_ADDR_EN.
- When defined, the block adds output rom_addr [18:0].
  - Reset value 0; clears to 0 on frame_start.
  - Increments by 1 on each pix_en where video_on is high in the same cycle.
  - Holds during blanking, giving linear address v*H_ACTIVE+h.
  - Implemented incrementally, with no multiplier.
  - Final value in a frame is 307199.
- When not defined, the port and its logic are absent.

Decomposition:
- Package vga_timing_pkg holds:
  - Default timing constants and derived H_TOTAL/V_TOTAL functions.
  - typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} vga_phase_t.
  - typedef logic [9:0] vga_coord_t.
- Sub-module vga_pix_strobe (parameter CLK_DIV; ports vga_clk, reset, pix_en) produces the pixel strobe; the top instantiates it once.

Test Plan:
- Reset release, CLK_DIV=2 → first pix_en at cycle 2; frame_start and line_start pulse together with h_count=0, v_count=0, video_on=1.
- Free run, one line → hsync low exactly for h_count 656..751; the line measures 1600 vga_clk cycles; video_on falls as h_count goes 639→640.
- Free run, one full frame → vsync low for v_count 490..491 (3200 cycles); frame_start period 840000 vga_clk cycles; v_count wraps 524→0.
- CLK_DIV=1 and SYNC_POL=1 → pix_en constantly high; hsync high for h_count 656..751; frame period 420000 cycles.
- Assert reset at h_count=300, v_count=200 → outputs return to reset values immediately; after release the raster restarts from (0,0) with frame_start.
- VGA_SYNC_TIMING_ROM_ADDR_EN defined → rom_addr=640 at (h=0, v=1); holds 639 through blanking of line 0; reaches 307199 at (639,479); returns to 0 on the next frame_start.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared types and default timing for the VGA raster generator.
//   - Default 640x480@60 timing constants (pixels / lines).
//   - h_total / v_total helpers for the derived totals.
//   - vga_phase_t : phase of one raster axis (active, front porch, sync,
//                   back porch).
//   - vga_coord_t : 10-bit pixel column / line number.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_SYNC_POL = 0;

  // Largest total a 10-bit coordinate can count through.
  localparam int COORD_LIMIT  = 1024;

  typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} vga_phase_t;
  typedef logic [9:0] vga_coord_t;

  function automatic int h_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_pix_strobe.sv
// ---------------------------------------------------------------------------
// vga_pix_strobe
// Single-cycle pixel strobe derived from vga_clk, used instead of a divided
// clock so the whole raster stays in one clock domain.
//   vga_clk : clock
//   reset   : asynchronous, active-low
//   pix_en  : registered one-cycle pulse every CLK_DIV cycles; the first
//             one appears CLK_DIV cycles after reset release. With
//             CLK_DIV=1 it is high every cycle after reset.
// ---------------------------------------------------------------------------
module vga_pix_strobe #(
  parameter int CLK_DIV = 2
) (
  input  logic vga_clk,
  input  logic reset,
  output logic pix_en
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_div_err
    $error("vga_pix_strobe: CLK_DIV must be >= 1");
  end

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          pix_en_q,  pix_en_d;

  always_comb begin
    pix_en_d  = (div_cnt_q == DIV_END);
    div_cnt_d = pix_en_d ? '0 : div_cnt_q + DW'(1);
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
      pix_en_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_en_q  <= pix_en_d;
    end
  end

  assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_sync_timing.sv
// ---------------------------------------------------------------------------
// vga_sync_timing
// 640x480@60 (by default) VGA raster timing generator, vga_clk domain only.
//   vga_clk     : clock
//   reset       : asynchronous, active-low
//   pix_en      : pixel strobe (one vga_clk pulse every CLK_DIV cycles)
//   h_count     : current pixel column, 0..H_TOTAL-1
//   v_count     : current line, 0..V_TOTAL-1
//   hsync/vsync : sync outputs, asserted level = SYNC_POL
//   video_on    : both axes in their active region
//   line_start  : one-cycle pulse when h_count becomes 0
//   frame_start : one-cycle pulse when (h_count,v_count) becomes (0,0)
//   rom_addr    : (only with VGA_SYNC_TIMING_ROM_ADDR_EN) linear address
//                 v*H_ACTIVE+h of the visible pixel, held during blanking
//
// The raster steps at the clock edge that ends a pix_en cycle. Every output
// is a register loaded from the next-state counters/phases, so syncs, pulses
// and video_on always line up with the h_count/v_count shown alongside them.
// Reset parks the raster on the last pixel of the frame, so the first step
// lands on (0,0) and fires frame_start/line_start.
// ---------------------------------------------------------------------------
module vga_sync_timing
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = DEF_SYNC_POL
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic        pix_en,
  output logic [9:0]  h_count,
  output logic [9:0]  v_count,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_SYNC_TIMING_ROM_ADDR_EN
  ,
  output logic [18:0] rom_addr
`endif
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Last coordinate of each phase; the phase is left after this value.
  localparam vga_coord_t H_ACT_END  = vga_coord_t'(H_ACTIVE - 1);
  localparam vga_coord_t H_FP_END   = vga_coord_t'(H_ACTIVE + H_FP - 1);
  localparam vga_coord_t H_SYNC_END = vga_coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam vga_coord_t H_END      = vga_coord_t'(H_TOTAL - 1);
  localparam vga_coord_t V_ACT_END  = vga_coord_t'(V_ACTIVE - 1);
  localparam vga_coord_t V_FP_END   = vga_coord_t'(V_ACTIVE + V_FP - 1);
  localparam vga_coord_t V_SYNC_END = vga_coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam vga_coord_t V_END      = vga_coord_t'(V_TOTAL - 1);

  localparam logic POL = (SYNC_POL != 0);

  if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT ||
      H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_err
    $error("vga_sync_timing: illegal timing parameters");
  end

  // -------------------------------------------------------------------------
  // Pixel strobe
  // -------------------------------------------------------------------------
  logic pix_en_w;

  vga_pix_strobe #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_strobe (
    .vga_clk (vga_clk),
    .reset   (reset),
    .pix_en  (pix_en_w)
  );

  // -------------------------------------------------------------------------
  // Raster counters
  // -------------------------------------------------------------------------
  vga_coord_t h_cnt_q, h_cnt_d;
  vga_coord_t v_cnt_q, v_cnt_d;
  logic       h_wrap, v_wrap;

  always_comb begin
    h_wrap  = pix_en_w && (h_cnt_q == H_END);
    v_wrap  = h_wrap && (v_cnt_q == V_END);
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en_w) h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
    if (h_wrap)   v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
  end

  // -------------------------------------------------------------------------
  // Phase FSMs: horizontal steps on pix_en, vertical on the horizontal wrap.
  // -------------------------------------------------------------------------
  vga_phase_t h_ph_q, h_ph_d;
  vga_phase_t v_ph_q, v_ph_d;

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      h_ph_q <= PH_BP;
      v_ph_q <= PH_BP;
    end else begin
      h_ph_q <= h_ph_d;
      v_ph_q <= v_ph_d;
    end
  end

  always_comb begin
    h_ph_d = h_ph_q;
    if (pix_en_w) begin
      case (h_ph_q)
        PH_ACTIVE: if (h_cnt_q == H_ACT_END)  h_ph_d = PH_FP;
        PH_FP:     if (h_cnt_q == H_FP_END)   h_ph_d = PH_SYNC;
        PH_SYNC:   if (h_cnt_q == H_SYNC_END) h_ph_d = PH_BP;
        PH_BP:     if (h_cnt_q == H_END)      h_ph_d = PH_ACTIVE;
        default:                              h_ph_d = PH_BP;
      endcase
    end
  end

  always_comb begin
    v_ph_d = v_ph_q;
    if (h_wrap) begin
      case (v_ph_q)
        PH_ACTIVE: if (v_cnt_q == V_ACT_END)  v_ph_d = PH_FP;
        PH_FP:     if (v_cnt_q == V_FP_END)   v_ph_d = PH_SYNC;
        PH_SYNC:   if (v_cnt_q == V_SYNC_END) v_ph_d = PH_BP;
        PH_BP:     if (v_cnt_q == V_END)      v_ph_d = PH_ACTIVE;
        default:                              v_ph_d = PH_BP;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registered outputs, all loaded from next-state values.
  // -------------------------------------------------------------------------
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic video_on_q, video_on_d;
  logic line_start_q, frame_start_q;

  always_comb begin
    hsync_d    = (h_ph_d == PH_SYNC) ? POL : ~POL;
    vsync_d    = (v_ph_d == PH_SYNC) ? POL : ~POL;
    video_on_d = (h_ph_d == PH_ACTIVE) && (v_ph_d == PH_ACTIVE);
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      h_cnt_q       <= H_END;
      v_cnt_q       <= V_END;
      hsync_q       <= ~POL;
      vsync_q       <= ~POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
    end
  end

  assign pix_en      = pix_en_w;
  assign h_count     = h_cnt_q;
  assign v_count     = v_cnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_SYNC_TIMING_ROM_ADDR_EN
  // Linear pixel address built by counting visible pixels, so it tracks
  // v*H_ACTIVE+h without a multiplier. Stepping into a visible pixel bumps
  // it; blanking holds the last visible address; the frame wrap clears it.
  logic [18:0] rom_addr_q, rom_addr_d;

  always_comb begin
    rom_addr_d = rom_addr_q;
    if (v_wrap)                      rom_addr_d = '0;
    else if (pix_en_w && video_on_d) rom_addr_d = rom_addr_q + 19'd1;
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) rom_addr_q <= '0;
    else        rom_addr_q <= rom_addr_d;
  end

  assign rom_addr = rom_addr_q;
`endif

endmodule

// File: tb/tb_vga_sync_timing.sv
module tb_vga_sync_timing;

  // Instance A: default 640x480 timing, CLK_DIV=2, active-low syncs.
  // Instance B: tiny raster, CLK_DIV=1, active-high syncs, for frame-level
  // checks within a short run.
  localparam int BD = 1, BHA = 8, BHF = 2, BHS = 3, BHB = 2;
  localparam int BVA = 6, BVF = 1, BVS = 2, BVB = 2;

  logic vga_clk = 1'b0;
  logic reset   = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic       pe_a, hs_a, vs_a, von_a, ls_a, fs_a;
  logic [9:0] h_a, v_a;
  logic       pe_b, hs_b, vs_b, von_b, ls_b, fs_b;
  logic [9:0] h_b, v_b;
`ifdef VGA_SYNC_TIMING_ROM_ADDR_EN
  logic [18:0] rom_a, rom_b;
`endif

  vga_sync_timing dut_a (
    .vga_clk(vga_clk), .reset(reset), .pix_en(pe_a), .h_count(h_a), .v_count(v_a),
    .hsync(hs_a), .vsync(vs_a), .video_on(von_a), .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_SYNC_TIMING_ROM_ADDR_EN
    , .rom_addr(rom_a)
`endif
  );

  vga_sync_timing #(
    .CLK_DIV(BD), .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB), .SYNC_POL(1)
  ) dut_b (
    .vga_clk(vga_clk), .reset(reset), .pix_en(pe_b), .h_count(h_b), .v_count(v_b),
    .hsync(hs_b), .vsync(vs_b), .video_on(von_b), .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_SYNC_TIMING_ROM_ADDR_EN
    , .rom_addr(rom_b)
`endif
  );

  typedef struct {
    int pe, h, v, hs, vs, von, ls, fs, rom;
  } obs_t;

  typedef struct {
    int   e;
    obs_t ex;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;
  int e;            // vga_clk edges since reset release
  bit chk_on = 1'b0;

  always @(posedge vga_clk or negedge reset)
    if (!reset) e <= 0;
    else        e <= e + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  // Reference: raster position derived arithmetically from the number of
  // clock edges since reset release.
  function automatic obs_t ref_model(int ed, int D, int HA, int HF, int HS, int HB,
                                     int VA, int VF, int VS, int VB, int POL);
    obs_t o;
    int ht, vt, p, idx;
    bit fresh;
    ht = HA + HF + HS + HB;
    vt = VA + VF + VS + VB;
    o.pe  = (ed > 0 && ed % D == 0) ? 1 : 0;
    o.h   = ht - 1;  o.v  = vt - 1;
    o.hs  = 1 - POL; o.vs = 1 - POL;
    o.von = 0; o.ls = 0; o.fs = 0; o.rom = 0;
    p = (ed > 0) ? (ed - 1) / D : 0;
    if (p > 0) begin
      idx   = (p - 1) % (ht * vt);
      o.h   = idx % ht;
      o.v   = idx / ht;
      fresh = ((ed - 1) % D == 0);
      o.ls  = (fresh && o.h == 0) ? 1 : 0;
      o.fs  = (fresh && idx == 0) ? 1 : 0;
      o.hs  = (o.h >= HA + HF && o.h < HA + HF + HS) ? POL : 1 - POL;
      o.vs  = (o.v >= VA + VF && o.v < VA + VF + VS) ? POL : 1 - POL;
      o.von = (o.h < HA && o.v < VA) ? 1 : 0;
      o.rom = (o.v < VA) ? o.v * HA + ((o.h < HA) ? o.h : HA - 1) : VA * HA - 1;
    end
    return o;
  endfunction

  function automatic obs_t exp_a(int ed);
    return ref_model(ed, 2, 640, 16, 96, 48, 480, 10, 2, 33, 0);
  endfunction

  function automatic obs_t exp_b(int ed);
    return ref_model(ed, BD, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, 1);
  endfunction

  function automatic obs_t smp_a();
    obs_t o;
    o.pe = int'(pe_a); o.h = int'(h_a); o.v = int'(v_a); o.hs = int'(hs_a);
    o.vs = int'(vs_a); o.von = int'(von_a); o.ls = int'(ls_a); o.fs = int'(fs_a);
    o.rom = 0;
`ifdef VGA_SYNC_TIMING_ROM_ADDR_EN
    o.rom = int'(rom_a);
`endif
    return o;
  endfunction

  function automatic obs_t smp_b();
    obs_t o;
    o.pe = int'(pe_b); o.h = int'(h_b); o.v = int'(v_b); o.hs = int'(hs_b);
    o.vs = int'(vs_b); o.von = int'(von_b); o.ls = int'(ls_b); o.fs = int'(fs_b);
    o.rom = 0;
`ifdef VGA_SYNC_TIMING_ROM_ADDR_EN
    o.rom = int'(rom_b);
`endif
    return o;
  endfunction

  task automatic cmp_obs(input string tag, input obs_t act, input obs_t ex);
    chk({tag, ".pix_en"},      act.pe,  ex.pe);
    chk({tag, ".h_count"},     act.h,   ex.h);
    chk({tag, ".v_count"},     act.v,   ex.v);
    chk({tag, ".hsync"},       act.hs,  ex.hs);
    chk({tag, ".vsync"},       act.vs,  ex.vs);
    chk({tag, ".video_on"},    act.von, ex.von);
    chk({tag, ".line_start"},  act.ls,  ex.ls);
    chk({tag, ".frame_start"}, act.fs,  ex.fs);
`ifdef VGA_SYNC_TIMING_ROM_ADDR_EN
    chk({tag, ".rom_addr"},    act.rom, ex.rom);
`endif
  endtask

  // Cycle-by-cycle scoreboard against the reference model.
  always @(negedge vga_clk) begin
    if (chk_on) begin
      cmp_obs("cyc_a", smp_a(), exp_a(e));
      cmp_obs("cyc_b", smp_b(), exp_b(e));
    end
  end

  task automatic release_reset();
    @(negedge vga_clk);
    #2 reset = 1'b1;
  endtask

  task automatic async_reset(input string tag);
    @(posedge vga_clk);
    #3 reset = 1'b0;
    #1;
    cmp_obs({tag, "_a"}, smp_a(), exp_a(0));
    cmp_obs({tag, "_b"}, smp_b(), exp_b(0));
  endtask

  vec_t tbl[13];

  initial begin
    int guard, cyc, lo, von_n, prev_v;
    // {e, {pe, h, v, hs, vs, von, ls, fs, rom}} for instance A
    tbl[0]  = '{1,    '{0, 799, 524, 1, 1, 0, 0, 0, 0}};
    tbl[1]  = '{2,    '{1, 799, 524, 1, 1, 0, 0, 0, 0}};
    tbl[2]  = '{3,    '{0,   0,   0, 1, 1, 1, 1, 1, 0}};
    tbl[3]  = '{4,    '{1,   0,   0, 1, 1, 1, 0, 0, 0}};
    tbl[4]  = '{5,    '{0,   1,   0, 1, 1, 1, 0, 0, 1}};
    tbl[5]  = '{1281, '{0, 639,   0, 1, 1, 1, 0, 0, 639}};
    tbl[6]  = '{1283, '{0, 640,   0, 1, 1, 0, 0, 0, 639}};
    tbl[7]  = '{1313, '{0, 655,   0, 1, 1, 0, 0, 0, 639}};
    tbl[8]  = '{1315, '{0, 656,   0, 0, 1, 0, 0, 0, 639}};
    tbl[9]  = '{1505, '{0, 751,   0, 0, 1, 0, 0, 0, 639}};
    tbl[10] = '{1507, '{0, 752,   0, 1, 1, 0, 0, 0, 639}};
    tbl[11] = '{1601, '{0, 799,   0, 1, 1, 0, 0, 0, 639}};
    tbl[12] = '{1603, '{0,   0,   1, 1, 1, 1, 1, 0, 640}};

    // Reset state.
    repeat (3) @(posedge vga_clk);
    #1;
    cmp_obs("rst_a", smp_a(), exp_a(0));
    chk("rst_b.hsync", int'(hs_b), 0);
    chk("rst_b.h_count", int'(h_b), BHA + BHF + BHS + BHB - 1);
    chk_on = 1'b1;

    // Table-driven walk through line 0 of instance A.
    release_reset();
    for (int i = 0; i < 13; i++) begin
      guard = 0;
      while (e < tbl[i].e && guard < 5000) begin
        @(negedge vga_clk);
        guard++;
      end
      if (e != tbl[i].e) fail_now($sformatf("tbl%0d_sync", i));
      else cmp_obs($sformatf("tbl%0d", i), smp_a(), tbl[i].ex);
    end

    // One full line of A: period, hsync width, visible width.
    guard = 0;
    while (!ls_a && guard < 4000) begin @(negedge vga_clk); guard++; end
    if (!ls_a) fail_now("a_line_wait");
    cyc = 0; lo = 0; von_n = 0;
    do begin
      if (!hs_a) lo++;
      if (von_a) von_n++;
      @(negedge vga_clk);
      cyc++;
    end while (!ls_a && cyc < 4000);
    chk("a_line_period", cyc, 1600);
    chk("a_hsync_cycles", lo, 192);
    chk("a_video_cycles", von_n, 1280);

    // One full frame of B: period, vsync width, v wrap, visible pixels.
    guard = 0;
    while (!fs_b && guard < 1000) begin @(negedge vga_clk); guard++; end
    if (!fs_b) fail_now("b_frame_wait");
    cyc = 0; lo = 0; von_n = 0; prev_v = 0;
    do begin
      if (vs_b) lo++;
      if (von_b) von_n++;
      prev_v = int'(v_b);
      @(negedge vga_clk);
      cyc++;
    end while (!fs_b && cyc < 1000);
    chk("b_frame_period", cyc, 165);
    chk("b_vsync_cycles", lo, 30);
    chk("b_video_cycles", von_n, 48);
    chk("b_vwrap_from", prev_v, 10);
    chk("b_vwrap_to", int'(v_b), 0);

`ifdef VGA_SYNC_TIMING_ROM_ADDR_EN
    // Last visible pixel of B's frame, then the clear on the next frame.
    guard = 0;
    while (!(h_b == 10'd7 && v_b == 10'd5) && guard < 1000) begin
      @(negedge vga_clk); guard++;
    end
    chk("b_rom_last", int'(rom_b), 47);
    guard = 0;
    while (!fs_b && guard < 1000) begin @(negedge vga_clk); guard++; end
    chk("b_rom_clear", int'(rom_b), 0);
`endif

    // Mid-line reset of A at h=300, then clean restart.
    guard = 0;
    while (h_a != 10'd300 && guard < 4000) begin @(negedge vga_clk); guard++; end
    if (h_a != 10'd300) fail_now("a_h300_wait");
    async_reset("mid_a");
    repeat (2) @(posedge vga_clk);
    release_reset();
    guard = 0;
    while (!fs_a && guard < 10) begin @(negedge vga_clk); guard++; end
    chk("restart_fs", int'(fs_a), 1);
    chk("restart_ls", int'(ls_a), 1);
    chk("restart_h", int'(h_a), 0);
    chk("restart_v", int'(v_a), 0);
    chk("restart_e", e, 3);

    // Mid-frame reset of B at (5,3).
    guard = 0;
    while (!(h_b == 10'd5 && v_b == 10'd3) && guard < 1000) begin
      @(negedge vga_clk); guard++;
    end
    if (!(h_b == 10'd5 && v_b == 10'd3)) fail_now("b_mid_wait");
    async_reset("mid_b");
    repeat (3) @(posedge vga_clk);
    release_reset();

    // Random run lengths and reset pulses; the scoreboard checks every cycle.
    for (int r = 0; r < 16; r++) begin
      int run, hold, off;
      run  = int'($urandom_range(20, 2400));
      hold = int'($urandom_range(1, 4));
      off  = int'($urandom_range(1, 4));
      repeat (run) @(posedge vga_clk);
      #(off) reset = 1'b0;
      #1;
      cmp_obs("rnd_rst_a", smp_a(), exp_a(0));
      cmp_obs("rnd_rst_b", smp_b(), exp_b(0));
      repeat (hold) @(posedge vga_clk);
      release_reset();
    end
    repeat (200) @(posedge vga_clk);

    @(negedge vga_clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    fail_now("watchdog");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
